// File: rtl/ram_imagen_arbiter_if.sv
// Read-requester and frame-buffer RAM signals of the image frame-buffer arbiter.
// slave = arbiter side, master = requester / RAM side.
interface ram_imagen_arbiter_if #(
  parameter int ADDR_W = 19
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_adr;
  logic              rd_ack;
  logic [7:0]        rd_dat;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_adr;
  logic [7:0]        ram_dat_w;
  logic [7:0]        ram_dat_r;

  modport slave (
    input  rd_req, rd_adr, ram_dat_r,
    output rd_ack, rd_dat, ram_we, ram_re, ram_adr, ram_dat_w
  );

  modport master (
    output rd_req, rd_adr, ram_dat_r,
    input  rd_ack, rd_dat, ram_we, ram_re, ram_adr, ram_dat_w
  );
endinterface

// File: rtl/ram_imagen_arbiter.sv
// Frame-buffer port owner: sequences one camera frame capture and shares the single
// RAM port with a bus reader through a one-pixel skid register.
//   state   | meaning
//   IDLE    | no capture armed
//   ARMED   | waiting for cam_frame_start, pixels ignored
//   CAPTURE | writing pixels at wr_adr
//   DONE    | full frame written
module ram_imagen_arbiter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  logic                 cap_start,
  output logic                 cap_busy,
  output logic                 cap_done,
  output logic                 frame_err,
  input  logic                 cam_frame_start,
  input  logic                 cam_pix_valid,
  input  logic [7:0]           cam_pix_data,
  ram_imagen_arbiter_if.slave  bus
);
  localparam int PIX = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIX - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_adr, wr_adr_nxt;
  logic              skid_full, skid_full_nxt;
  logic [7:0]        skid_dat, skid_dat_nxt;
  logic              deferred, deferred_nxt;
  logic              frame_err_nxt;
  logic              rd_ack_q;
  logic [7:0]        rd_dat_q;

  logic restart, cap_pix, skid_v, rd_elig;
  logic grant_skid, grant_rd, grant_dir, wr_any, wr_last;

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state     <= IDLE;
      wr_adr    <= '0;
      skid_full <= 1'b0;
      skid_dat  <= '0;
      deferred  <= 1'b0;
      frame_err <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_dat_q  <= '0;
    end else begin
      state     <= state_nxt;
      wr_adr    <= wr_adr_nxt;
      skid_full <= skid_full_nxt;
      skid_dat  <= skid_dat_nxt;
      deferred  <= deferred_nxt;
      frame_err <= frame_err_nxt;
      rd_ack_q  <= grant_rd;
      if (rd_ack_q) rd_dat_q <= bus.ram_dat_r;
    end
  end

  always_comb begin
    restart    = (state == CAPTURE) && cam_frame_start;
    cap_pix    = (state == CAPTURE) && cam_pix_valid && !cam_frame_start;
    // a restart flushes the skid, so its pixel no longer competes for the port
    skid_v     = skid_full && !restart;
    rd_elig    = bus.rd_req && !rd_ack_q;
    grant_skid = skid_v;
    grant_rd   = rd_elig && !skid_v && (!cap_pix || deferred);
    grant_dir  = cap_pix && !skid_v && !grant_rd;
    wr_any     = grant_skid || grant_dir;
    wr_last    = wr_any && (wr_adr == LAST);

    state_nxt     = state;
    wr_adr_nxt    = wr_adr;
    skid_full_nxt = skid_full;
    skid_dat_nxt  = skid_dat;
    deferred_nxt  = deferred;
    frame_err_nxt = frame_err;

    if (rd_elig) deferred_nxt = !grant_rd;
    if (wr_any) wr_adr_nxt = wr_adr + ADDR_W'(1);

    // pixels arriving while the last address is written belong to no frame
    if (grant_skid) begin
      skid_full_nxt = cap_pix && !wr_last;
      skid_dat_nxt  = cam_pix_data;
    end else if (grant_rd && cap_pix) begin
      skid_full_nxt = 1'b1;
      skid_dat_nxt  = cam_pix_data;
    end

    case (state)
      IDLE, DONE: begin
        if (cap_start) begin
          state_nxt     = ARMED;
          wr_adr_nxt    = '0;
          frame_err_nxt = 1'b0;
        end
      end
      ARMED: begin
        if (cam_frame_start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (restart) begin
          frame_err_nxt = 1'b1;
          wr_adr_nxt    = '0;
          skid_full_nxt = 1'b0;
        end else if (wr_last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ram_we    = rst && wr_any;
  assign bus.ram_re    = rst && grant_rd;
  assign bus.ram_adr   = !rst      ? '0 :
                         grant_rd  ? bus.rd_adr :
                         wr_any    ? wr_adr : '0;
  assign bus.ram_dat_w = !rst       ? '0 :
                         grant_skid ? skid_dat :
                         grant_dir  ? cam_pix_data : '0;
  assign bus.rd_ack    = rd_ack_q;
  assign bus.rd_dat    = rd_ack_q ? bus.ram_dat_r : rd_dat_q;

  assign cap_busy = (state == ARMED) || (state == CAPTURE);
  assign cap_done = (state == DONE);
endmodule
